// File: rtl/pb_debouncer_multi.sv
// Multi-channel push-button conditioner: synchroniser, debounce, press/release
// pulses, plus a per-channel hold FSM for long-press and auto-repeat pulses.
//
// Ports:
//   clk              base clock
//   rst              synchronous active-high reset
//   pb               raw asynchronous button pins (one bit per channel)
//   pressed_status   debounced level, 1 = pressed
//   pressed_pulse    1-cycle pulse on an accepted press
//   released_pulse   1-cycle pulse on an accepted release
//   long_press_pulse 1-cycle pulse HOLD_CYCLES after pressed_pulse
//   repeat_pulse     1-cycle pulse every REPEAT_CYCLES after a long press
module pb_debouncer_multi #(
   parameter int N_CH          = 4,
   parameter int DELAY         = 15,
   parameter int HOLD_CYCLES   = 1000,
   parameter int REPEAT_CYCLES = 200,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] pb,
   output logic [N_CH-1:0] pressed_status,
   output logic [N_CH-1:0] pressed_pulse,
   output logic [N_CH-1:0] released_pulse,
   output logic [N_CH-1:0] long_press_pulse,
   output logic [N_CH-1:0] repeat_pulse
);

   localparam int CW   = $clog2(DELAY + 1);
   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                         HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HW   = $clog2(HMAX + 1);

   localparam logic [CW-1:0] DLY_LAST  = CW'(DELAY - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam bit            REP_EN    = (REPEAT_CYCLES > 0);
   localparam logic [HW-1:0] REP_LAST  =
      HW'(REP_EN ? REPEAT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } hold_state_t;

   logic [N_CH-1:0] pb_n;

   assign pb_n = pb ^ {N_CH{ACTIVE_LOW}};

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic        sync1;
      logic        sync2;
      logic        status;
      logic [CW-1:0] cnt;
      logic        toggle;
      logic        press_ev;
      logic        rel_ev;
      hold_state_t state;
      hold_state_t state_nx;
      logic [HW-1:0] hcnt;
      logic [HW-1:0] hcnt_nx;
      logic        long_nx;
      logic        rep_nx;
      logic        pp_q;
      logic        rp_q;
      logic        lp_q;
      logic        rpt_q;

      // The level flips on the DELAY-th consecutive disagreeing cycle.
      assign toggle   = (sync2 != status) && (cnt == DLY_LAST);
      assign press_ev = toggle & ~status;
      assign rel_ev   = toggle &  status;

      always_ff @(posedge clk) begin
         if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            status <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
            hcnt   <= '0;
            pp_q   <= 1'b0;
            rp_q   <= 1'b0;
            lp_q   <= 1'b0;
            rpt_q  <= 1'b0;
         end else begin
            sync1 <= pb_n[i];
            sync2 <= sync1;
            if (sync2 == status) begin
               cnt <= '0;
            end else if (toggle) begin
               cnt    <= '0;
               status <= ~status;
            end else begin
               cnt <= cnt + CW'(1);
            end
            state <= state_nx;
            hcnt  <= hcnt_nx;
            pp_q  <= press_ev;
            rp_q  <= rel_ev;
            lp_q  <= long_nx;
            rpt_q <= rep_nx;
         end
      end

      // Release wins over everything so no long/repeat pulse can
      // share a cycle with released_pulse.
      always_comb begin
         state_nx = state;
         hcnt_nx  = hcnt;
         long_nx  = 1'b0;
         rep_nx   = 1'b0;
         if (rel_ev) begin
            state_nx = IDLE;
            hcnt_nx  = '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (press_ev) begin
                     state_nx = PRESSED;
                     hcnt_nx  = '0;
                  end
               end
               PRESSED: begin
                  if (hcnt == HOLD_LAST) begin
                     state_nx = HELD;
                     hcnt_nx  = '0;
                     long_nx  = 1'b1;
                  end else begin
                     hcnt_nx = hcnt + HW'(1);
                  end
               end
               HELD: begin
                  if (REP_EN) begin
                     if (hcnt == REP_LAST) begin
                        hcnt_nx = '0;
                        rep_nx  = 1'b1;
                     end else begin
                        hcnt_nx = hcnt + HW'(1);
                     end
                  end
               end
               default: begin
                  state_nx = IDLE;
                  hcnt_nx  = '0;
               end
            endcase
         end
      end

      assign pressed_status[i]   = status;
      assign pressed_pulse[i]    = pp_q;
      assign released_pulse[i]   = rp_q;
      assign long_press_pulse[i] = lp_q;
      assign repeat_pulse[i]     = rpt_q;
   end

endmodule

// File: tb/tb_pb_debouncer_multi.sv
// Self-checking bench for pb_debouncer_multi: three instances (default,
// no-repeat, active-low) checked against a scoreboard of expected pulses.
module tb_pb_debouncer_multi;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] pb_a, pb_b, pb_c;
   logic [1:0] st_a, pp_a, rp_a, lp_a, rpt_a;
   logic [1:0] st_b, pp_b, rp_b, lp_b, rpt_b;
   logic [1:0] st_c, pp_c, rp_c, lp_c, rpt_c;

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      int         cyc;
      int         dut;
      logic [7:0] ev;
   } exp_t;

   exp_t sb[$];
   logic [7:0] act [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pb_debouncer_multi #(.N_CH(2), .DELAY(4), .HOLD_CYCLES(20),
      .REPEAT_CYCLES(5), .ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst(rst), .pb(pb_a),
      .pressed_status(st_a), .pressed_pulse(pp_a),
      .released_pulse(rp_a), .long_press_pulse(lp_a),
      .repeat_pulse(rpt_a));

   pb_debouncer_multi #(.N_CH(2), .DELAY(4), .HOLD_CYCLES(20),
      .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b0)) dut_b (
      .clk(clk), .rst(rst), .pb(pb_b),
      .pressed_status(st_b), .pressed_pulse(pp_b),
      .released_pulse(rp_b), .long_press_pulse(lp_b),
      .repeat_pulse(rpt_b));

   pb_debouncer_multi #(.N_CH(2), .DELAY(4), .HOLD_CYCLES(20),
      .REPEAT_CYCLES(5), .ACTIVE_LOW(1'b1)) dut_c (
      .clk(clk), .rst(rst), .pb(pb_c),
      .pressed_status(st_c), .pressed_pulse(pp_c),
      .released_pulse(rp_c), .long_press_pulse(lp_c),
      .repeat_pulse(rpt_c));

   assign act[0] = {rpt_a, lp_a, rp_a, pp_a};
   assign act[1] = {rpt_b, lp_b, rp_b, pp_b};
   assign act[2] = {rpt_c, lp_c, rp_c, pp_c};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ev(input logic [1:0] pp,
      input logic [1:0] rp, input logic [1:0] lp, input logic [1:0] rpt);
      return {rpt, lp, rp, pp};
   endfunction

   task automatic push(input int d, input int off, input logic [7:0] e);
      exp_t x;
      x.cyc = cyc + off;
      x.dut = d;
      x.ev  = e;
      sb.push_back(x);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pop everything due this cycle; any pulse activity or any due
   // expectation is compared, so both spurious and missing pulses show.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         logic [7:0] e;
         int i;
         e = 8'h00;
         i = 0;
         while (i < sb.size()) begin
            if (sb[i].dut == d && sb[i].cyc == cyc) begin
               e = e | sb[i].ev;
               sb.delete(i);
            end else begin
               i++;
            end
         end
         if (act[d] != 8'h00 || e != 8'h00)
            chk($sformatf("ev d%0d c%0d", d, cyc), 32'(act[d]), 32'(e));
      end
   end

   initial begin
      int k;
      rst  = 1'b1;
      pb_a = 2'b11;
      pb_b = 2'b00;
      pb_c = 2'b11;

      // reset with buttons held, then full re-acceptance
      tick(5);
      chk("rst_st_a", 32'(st_a), 32'h0);
      chk("rst_st_c", 32'(st_c), 32'h0);
      rst = 1'b0;
      push(0, 6, ev(2'b11, 2'b00, 2'b00, 2'b00));
      tick(5);
      chk("rx_st_early", 32'(st_a), 32'h0);
      tick(1);
      chk("rx_st", 32'(st_a), 32'h3);
      pb_a = 2'b00;
      push(0, 6, ev(2'b00, 2'b11, 2'b00, 2'b00));
      tick(6);
      chk("rx_rel_st", 32'(st_a), 32'h0);
      tick(5);

      // glitch of 3 cycles is rejected
      pb_a[0] = 1'b1;
      tick(3);
      pb_a[0] = 1'b0;
      tick(10);
      chk("glitch_st", 32'(st_a), 32'h0);

      // press, long press, repeats; release lands on a would-be repeat
      k = cyc;
      pb_a[0] = 1'b1;
      push(0, 6, ev(2'b01, 2'b00, 2'b00, 2'b00));
      push(0, 26, ev(2'b00, 2'b00, 2'b01, 2'b00));
      for (int r = 0; r < 4; r++)
         push(0, 31 + 5 * r, ev(2'b00, 2'b00, 2'b00, 2'b01));
      push(0, 51, ev(2'b00, 2'b01, 2'b00, 2'b00));
      tick(6);
      chk("press_st", 32'(st_a), 32'h1);
      tick(39);
      chk("hold_cyc", 32'(cyc - k), 32'd45);
      pb_a[0] = 1'b0;
      tick(5);
      chk("held_st", 32'(st_a), 32'h1);
      tick(1);
      chk("rel_st", 32'(st_a), 32'h0);
      tick(30);

      // simultaneous press on ch0 and release on ch1
      pb_a[1] = 1'b1;
      push(0, 6, ev(2'b10, 2'b00, 2'b00, 2'b00));
      tick(6);
      pb_a = 2'b01;
      push(0, 6, ev(2'b01, 2'b10, 2'b00, 2'b00));
      tick(6);
      chk("simul_st", 32'(st_a), 32'h1);
      pb_a = 2'b00;
      push(0, 6, ev(2'b00, 2'b01, 2'b00, 2'b00));
      tick(6);
      chk("simul_rel_st", 32'(st_a), 32'h0);
      tick(5);

      // repeat disabled: long press only
      pb_b[0] = 1'b1;
      push(1, 6, ev(2'b01, 2'b00, 2'b00, 2'b00));
      push(1, 26, ev(2'b00, 2'b00, 2'b01, 2'b00));
      tick(40);
      chk("norep_st", 32'(st_b), 32'h1);
      pb_b[0] = 1'b0;
      push(1, 6, ev(2'b00, 2'b01, 2'b00, 2'b00));
      tick(6);
      chk("norep_rel_st", 32'(st_b), 32'h0);
      tick(10);

      // reset while HELD, button still pressed afterwards
      pb_a[0] = 1'b1;
      push(0, 6, ev(2'b01, 2'b00, 2'b00, 2'b00));
      push(0, 26, ev(2'b00, 2'b00, 2'b01, 2'b00));
      push(0, 31, ev(2'b00, 2'b00, 2'b00, 2'b01));
      tick(33);
      rst = 1'b1;
      tick(1);
      chk("rst_held_st", 32'(st_a), 32'h0);
      tick(2);
      rst = 1'b0;
      push(0, 6, ev(2'b01, 2'b00, 2'b00, 2'b00));
      tick(5);
      chk("rst_exit_st", 32'(st_a), 32'h0);
      tick(1);
      chk("reaccept_st", 32'(st_a), 32'h1);
      pb_a[0] = 1'b0;
      push(0, 6, ev(2'b00, 2'b01, 2'b00, 2'b00));
      tick(6);
      chk("reacc_rel_st", 32'(st_a), 32'h0);
      tick(3);

      // active-low pins
      pb_c[0] = 1'b0;
      push(2, 6, ev(2'b01, 2'b00, 2'b00, 2'b00));
      tick(6);
      chk("al_st", 32'(st_c), 32'h1);
      pb_c = 2'b11;
      push(2, 6, ev(2'b00, 2'b01, 2'b00, 2'b00));
      tick(6);
      chk("al_rel_st", 32'(st_c), 32'h0);
      tick(5);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pb_debouncer_multi.md
Name: pb_debouncer_multi

Overview:
N-channel push-button conditioner for board-level buttons. Each channel has its own 2-flop synchroniser, counter-based debounce, and clean press/release pulses. A new per-channel hold FSM adds long-press detection and auto-repeat pulses. Sits between raw FPGA button pins and user control logic; all outputs are synchronous to clk.

Parameters:
N_CH, 4, number of independent button channels (>=1)
DELAY, 15, consecutive stable synchronised cycles required to accept a level change (>=2)
HOLD_CYCLES, 1000, cycles from pressed_pulse to long_press_pulse (>=1)
REPEAT_CYCLES, 200, period of repeat_pulse while held after long press; 0 disables repeat
ACTIVE_LOW, 0, 1 = raw pins read 0 when pressed (inverted before synchroniser)

Ports:
clk  in  1  base clock
rst  in  1  synchronous active-high reset
pb  in  N_CH  raw asynchronous button inputs
pressed_status  out  N_CH  debounced level, 1 = pressed
pressed_pulse  out  N_CH  1-cycle pulse on accepted press
released_pulse  out  N_CH  1-cycle pulse on accepted release
long_press_pulse  out  N_CH  1-cycle pulse when hold threshold reached
repeat_pulse  out  N_CH  1-cycle periodic pulse during long hold

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), fixed.
- Reset: all synchroniser flops, counters, FSM state and all outputs = 0 on the first edge with rst=1; held at 0 while rst=1, regardless of pb.
- Polarity: pb_n = pb XOR {N_CH{ACTIVE_LOW}}, applied before the 2-flop synchroniser. pb_sync lags pb_n by 2 edges.
- Debounce per channel: counter clears on any cycle where pb_sync == pressed_status. It increments on each disagreeing cycle. On the edge where it equals DELAY-1 with disagreement still present, pressed_status toggles and the counter clears.
- Debounce latency: pb_n stable from edge k, so pb_sync changes at k+2 and pressed_status changes at edge k+2+DELAY. Any agreeing cycle before that restarts the count.
- Counter width: $clog2(DELAY+1). It never wraps.
- Pulses are registered and asserted exactly in the first cycle pressed_status shows its new value: pressed_pulse on a 0->1 toggle, released_pulse on a 1->0 toggle. Never both in the same cycle on one channel.
- Hold FSM per channel has states IDLE, PRESSED and HELD, plus a hold counter of width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1).
  - IDLE -> PRESSED on a press toggle; counter = 0.
  - PRESSED: counter +1 per cycle. When counter == HOLD_CYCLES-1, assert long_press_pulse next cycle, go to HELD, counter = 0. long_press_pulse is therefore exactly HOLD_CYCLES cycles after pressed_pulse.
  - HELD: if REPEAT_CYCLES>0, counter +1 per cycle. When counter == REPEAT_CYCLES-1, assert repeat_pulse next cycle and set counter = 0. First repeat is REPEAT_CYCLES after long_press_pulse, then every REPEAT_CYCLES cycles.
  - A release toggle from any state -> IDLE, counter cleared. No long or repeat pulse is emitted in or after the cycle carrying released_pulse.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous, independent outputs.
- Reset mid-operation aborts debounce counts and the FSM. No pulse is emitted on reset exit. After reset, a still-pressed button is re-accepted through the full debounce latency.

Test Plan:
Use N_CH=2, DELAY=4, HOLD_CYCLES=20, REPEAT_CYCLES=5, ACTIVE_LOW=0 unless stated.

1. Reset: pb=2'b11 during 5 reset cycles, then rst=0 at edge R -> all outputs 0 during reset; pressed_status=2'b11 and pressed_pulse=2'b11 at edge R+6, one cycle wide.
2. Glitch reject: pb[0] high for 3 cycles, then low -> pressed_status[0] stays 0; no pulse ever asserted.
3. Clean press/release: pb[0] rises at edge 10 -> pressed_status[0]=1 and pressed_pulse[0] at edge 16. pb[0] falls at edge 60 -> released_pulse[0] at edge 66, then status 0.
4. Long press and repeat: hold pb[0] so pressed_pulse[0] lands at edge P -> long_press_pulse[0] at P+20; repeat_pulse[0] at P+25, P+30, P+35 ... until release. After released_pulse no further pulses.
5. Independence and simultaneity: ch0 press accepted in the same cycle as ch1 release -> pressed_pulse=2'b01 and released_pulse=2'b10 in the same cycle. Separately, REPEAT_CYCLES=0 -> long press fires, no repeats.
6. Reset in HELD and polarity: assert rst during HELD -> all outputs 0 on the next edge, no pulses on exit. With ACTIVE_LOW=1, pb=0 held -> pressed_pulse after DELAY+2 cycles.
